led_blink_driver: RTL

//  Output-side counterpart of the button input chain: turns one-clock event pulses into

---
 rtl/gpio_pkg.sv | 18 +
 rtl/blink_timer.sv | 28 ++
 rtl/led_blink_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared GPIO constants, blink FSM state encoding and helpers
package gpio_pkg;

   localparam int CLK_HZ             = 100_000_000;
   localparam int DEFAULT_ON_CYCLES  = CLK_HZ / 10;
   localparam int DEFAULT_OFF_CYCLES = CLK_HZ / 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2
   } blink_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - loadable down-counter that holds at zero and flags done
module blink_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/led_blink_driver.sv
// rtl/led_blink_driver.sv - turns event pulses into discrete LED blinks, queueing
// events that arrive mid-blink so consecutive blinks never merge
module led_blink_driver
   import gpio_pkg::*;
#(
   parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
   parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
   parameter int PEND_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evt_pulse,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pend_count,
   output logic              overflow
);

   localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
   localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   blink_state_t      state, state_next;
   logic [PEND_W-1:0] pend_next;
   logic              overflow_next;
   logic              load;
   logic [TW-1:0]     load_value;
   logic              done;
   logic              queue;

   blink_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_value (load_value),
      .done       (done)
   );

   always_comb begin
      state_next    = state;
      pend_next     = pend_count;
      overflow_next = 1'b0;
      load          = 1'b0;
      load_value    = ON_LOAD;
      queue         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (evt_pulse) begin
               state_next = ST_ON;
               load       = 1'b1;
            end
         end
         ST_ON: begin
            queue = evt_pulse;
            if (done) begin
               state_next = ST_GAP;
               load       = 1'b1;
               load_value = OFF_LOAD;
            end
         end
         ST_GAP: begin
            if (done) begin
               // A pulse on the exit cycle cancels the dequeue, so a full queue never overflows here
               if (pend_count != '0) begin
                  state_next = ST_ON;
                  load       = 1'b1;
                  pend_next  = evt_pulse ? pend_count : pend_count - PEND_ONE;
               end else if (evt_pulse) begin
                  state_next = ST_ON;
                  load       = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               queue = evt_pulse;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (queue) begin
         if (pend_count != PEND_MAX) begin
            pend_next = pend_count + PEND_ONE;
         end else begin
            overflow_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         led        <= 1'b0;
         busy       <= 1'b0;
         pend_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_next;
         led        <= (state_next == ST_ON);
         busy       <= (state_next != ST_IDLE);
         pend_count <= pend_next;
         overflow   <= overflow_next;
      end
   end

endmodule
